// File: rtl/adc_dma_arbiter_pkg.sv
// Shared definitions for the ADC sample DMA: register map, CTRL bit positions, FSM states.
// No logic; latency and backpressure are defined by the modules that import it.
package adc_dma_arbiter_pkg;

    localparam int DMA_AW       = 13;
    localparam int DMA_DW       = 16;
    localparam int DMA_FIFO_LOG = 2;

    localparam logic [1:0] DMA_REG_BASE  = 2'd0;
    localparam logic [1:0] DMA_REG_LEN   = 2'd1;
    localparam logic [1:0] DMA_REG_CTRL  = 2'd2;
    localparam logic [1:0] DMA_REG_COUNT = 2'd3;

    // CTRL write bits
    localparam int CTRL_START    = 0;
    localparam int CTRL_CLR_DONE = 1;
    localparam int CTRL_CLR_OVF  = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_DONE    = 2'd3
    } dma_state_t;

    function automatic logic [2:0] ctrl_status(input logic ovf, input logic done, input logic busy);
        return {ovf, done, busy};
    endfunction

endpackage

// File: rtl/adc_dma_arbiter_if.sv
// Bundles the CPU data-port, IO register, ADC sample and RAM buses of the DMA arbiter.
// slave = arbiter side; master = CPU/ADC/RAM side.
interface adc_dma_arbiter_if
    import adc_dma_arbiter_pkg::*;
#(
    parameter int AW = DMA_AW,
    parameter int DW = DMA_DW
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;

    logic          io_sel;
    logic          io_wr;
    logic [1:0]    io_addr;
    logic [DW-1:0] io_wdata;
    logic [DW-1:0] io_rdata;

    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;

    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata,
        input  io_sel, io_wr, io_addr, io_wdata,
        output io_rdata,
        input  s_valid, s_data,
        output s_ready,
        output ram_addr, ram_we, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata,
        output io_sel, io_wr, io_addr, io_wdata,
        input  io_rdata,
        output s_valid, s_data,
        input  s_ready,
        input  ram_addr, ram_we, ram_wdata,
        output ram_rdata
    );

endinterface

// File: rtl/adc_dma_arbiter_sample_fifo.sv
// Synchronous FIFO with first-word-fall-through head; push/pop take effect at the clock edge.
// Caller must not push when full or pop when empty (both are ignored); flush empties it in one cycle.
module sample_fifo #(
    parameter int DW       = 16,
    parameter int FIFO_LOG = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);
    localparam int DEPTH = 1 << FIFO_LOG;

    logic [DW-1:0]     mem [DEPTH];
    logic [FIFO_LOG:0] wr_ptr;
    logic [FIFO_LOG:0] rd_ptr;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[FIFO_LOG] != rd_ptr[FIFO_LOG]) &&
                   (wr_ptr[FIFO_LOG-1:0] == rd_ptr[FIFO_LOG-1:0]);
    assign dout  = mem[rd_ptr[FIFO_LOG-1:0]];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
            if (pop  && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[FIFO_LOG-1:0]] <= din;
    end

endmodule

// File: rtl/adc_dma_arbiter.sv
// Shares the data RAM between the CPU and an ADC capture DMA; CPU always wins, DMA writes fill idle cycles.
// RAM mux is combinational (0 cycles); samples are buffered in a 4-deep FIFO and dropped with sticky ovf when it is full.
module adc_dma_arbiter
    import adc_dma_arbiter_pkg::*;
#(
    parameter int AW       = DMA_AW,
    parameter int DW       = DMA_DW,
    parameter int FIFO_LOG = DMA_FIFO_LOG
) (
    input  logic             clk,
    input  logic             reset,
    adc_dma_arbiter_if.slave bus
);
    dma_state_t    state_q, state_d;
    logic [AW-1:0] base_q;
    logic [AW:0]   len_q;
    logic [AW:0]   count_q;
    logic [AW:0]   acc_q;
    logic [AW:0]   acc_nxt;
    logic          done_q;
    logic          ovf_q;
    logic [AW-1:0] addr_q;

    logic          busy;
    logic          reg_wr;
    logic          ctrl_wr;
    logic          start;
    logic          dma_go;
    logic          overflow;
    logic          fifo_push;
    logic          fifo_full;
    logic          fifo_empty;
    logic [DW-1:0] fifo_head;
    logic [AW-1:0] dma_addr;

    logic          s_ready_c;
    logic [AW-1:0] ram_addr_c;
    logic          ram_we_c;
    logic [DW-1:0] ram_wdata_c;
    logic [DW-1:0] io_rdata_c;

    logic unused_io_bits;
    assign unused_io_bits = &{1'b0, bus.io_wdata[DW-1:AW+1]};

    assign busy      = (state_q != ST_IDLE);
    assign reg_wr    = bus.io_sel && bus.io_wr;
    assign ctrl_wr   = reg_wr && (bus.io_addr == DMA_REG_CTRL);
    assign start     = ctrl_wr && bus.io_wdata[CTRL_START] && (state_q == ST_IDLE);
    assign fifo_push = (state_q == ST_CAPTURE) && bus.s_valid && !fifo_full;
    assign overflow  = (state_q == ST_CAPTURE) && bus.s_valid && fifo_full;
    assign acc_nxt   = acc_q + {{AW{1'b0}}, fifo_push};
    assign dma_addr  = base_q + count_q[AW-1:0];
    // Held off during reset so a capture aborted by reset leaves no stray write behind.
    assign dma_go    = !reset && !bus.cpu_req && !fifo_empty && busy;

    sample_fifo #(
        .DW       (DW),
        .FIFO_LOG (FIFO_LOG)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (start),
        .push  (fifo_push),
        .din   (bus.s_data),
        .pop   (dma_go),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d   = state_q;
        s_ready_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                s_ready_c = 1'b1;
                if (start) state_d = (len_q == '0) ? ST_DONE : ST_CAPTURE;
            end
            ST_CAPTURE: begin
                s_ready_c = !fifo_full;
                if (acc_nxt >= len_q) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (fifo_empty && (count_q == len_q)) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ram_addr_c  = addr_q;
        ram_we_c    = 1'b0;
        ram_wdata_c = bus.cpu_wdata;
        if (bus.cpu_req) begin
            ram_addr_c  = bus.cpu_addr;
            ram_we_c    = bus.cpu_we;
            ram_wdata_c = bus.cpu_wdata;
        end else if (dma_go) begin
            ram_addr_c  = dma_addr;
            ram_we_c    = 1'b1;
            ram_wdata_c = fifo_head;
        end
    end

    always_comb begin
        io_rdata_c = '0;
        case (bus.io_addr)
            DMA_REG_BASE:  io_rdata_c      = DW'(base_q);
            DMA_REG_LEN:   io_rdata_c      = DW'(len_q);
            DMA_REG_CTRL:  io_rdata_c[2:0] = ctrl_status(ovf_q, done_q, busy);
            DMA_REG_COUNT: io_rdata_c      = DW'(count_q);
            default:       io_rdata_c      = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
            len_q   <= '0;
            count_q <= '0;
            acc_q   <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= ram_addr_c;
            if (reg_wr && (bus.io_addr == DMA_REG_BASE)) base_q <= bus.io_wdata[AW-1:0];
            if (reg_wr && (bus.io_addr == DMA_REG_LEN))  len_q  <= bus.io_wdata[AW:0];
            if (start) begin
                count_q <= '0;
                acc_q   <= '0;
            end else begin
                if (dma_go) count_q <= count_q + 1'b1;
                acc_q <= acc_nxt;
            end
            // Status sets take priority over a software clear in the same cycle.
            if (state_q == ST_DONE)                            done_q <= 1'b1;
            else if (ctrl_wr && bus.io_wdata[CTRL_CLR_DONE]) done_q <= 1'b0;
            if (overflow)                                     ovf_q  <= 1'b1;
            else if (ctrl_wr && bus.io_wdata[CTRL_CLR_OVF])  ovf_q  <= 1'b0;
        end
    end

    assign bus.s_ready   = s_ready_c;
    assign bus.ram_addr  = ram_addr_c;
    assign bus.ram_we    = ram_we_c;
    assign bus.ram_wdata = ram_wdata_c;
    assign bus.cpu_rdata = bus.ram_rdata;
    assign bus.io_rdata  = io_rdata_c;

endmodule
